// File: rtl/arch_state_loader_if.sv
// rtl/arch_state_loader_if.sv - boot-image load, RAT lookup, PRF write and core start signals
interface arch_state_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int PHY_WIDTH  = 6
) ();
  logic                  init_start;
  logic [ADDR_WIDTH-1:0] init_boot_pc;
  logic                  load_valid;
  logic                  load_ready;
  logic [REG_WIDTH-1:0]  load_reg;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic [REG_WIDTH-1:0]  rat_rd_idx;
  logic [PHY_WIDTH-1:0]  rat_rd_phys;
  logic                  prf_we;
  logic [PHY_WIDTH-1:0]  prf_waddr;
  logic [DATA_WIDTH-1:0] prf_wdata;
  logic                  core_hold;
  logic                  core_go;
  logic [ADDR_WIDTH-1:0] core_boot_pc;
  logic                  busy;
  logic [REG_WIDTH:0]    loaded_count;

  // Host, front RAT, PRF and core control as seen from outside the loader.
  modport master (
    output init_start, init_boot_pc, load_valid, load_reg, load_data, load_last, rat_rd_phys,
    input  load_ready, rat_rd_idx, prf_we, prf_waddr, prf_wdata,
    input  core_hold, core_go, core_boot_pc, busy, loaded_count
  );

  modport slave (
    input  init_start, init_boot_pc, load_valid, load_reg, load_data, load_last, rat_rd_phys,
    output load_ready, rat_rd_idx, prf_we, prf_waddr, prf_wdata,
    output core_hold, core_go, core_boot_pc, busy, loaded_count
  );
endinterface

// File: rtl/arch_state_loader.sv
// rtl/arch_state_loader.sv - zeroes the PRF through the front RAT, loads a register image, releases the core
module arch_state_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int ARCH_REGS  = 32,
  parameter int PHY_WIDTH  = 6
) (
  input logic               clk,
  input logic               rst,
  arch_state_loader_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCEPT, S_RELEASE, S_DONE} state_t;

  localparam logic [REG_WIDTH-1:0] LAST_IDX  = REG_WIDTH'(ARCH_REGS - 1);
  localparam logic [REG_WIDTH:0]   COUNT_MAX = (REG_WIDTH + 1)'(ARCH_REGS - 1);

  state_t                r_state;
  logic [REG_WIDTH-1:0]  r_counter;
  logic                  r_load_ready;
  logic                  r_prf_we;
  logic [PHY_WIDTH-1:0]  r_prf_waddr;
  logic [DATA_WIDTH-1:0] r_prf_wdata;
  logic                  r_core_hold;
  logic                  r_core_go;
  logic [ADDR_WIDTH-1:0] r_core_boot_pc;
  logic                  r_busy;
  logic [REG_WIDTH:0]    r_loaded_count;

  logic                  w_handshake;
  logic [REG_WIDTH-1:0]  w_rat_idx;

  assign w_handshake = (r_state == S_ACCEPT) && r_load_ready && bus.load_valid;

  // The RAT port is shared: the clear sweep drives it in CLEAR, the incoming beat in ACCEPT.
  always_comb begin
    w_rat_idx = '0;
    case (r_state)
      S_CLEAR:  w_rat_idx = r_counter;
      S_ACCEPT: w_rat_idx = bus.load_reg;
      default:  w_rat_idx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_counter      <= '0;
      r_load_ready   <= 1'b0;
      r_prf_we       <= 1'b0;
      r_prf_waddr    <= '0;
      r_prf_wdata    <= '0;
      r_core_hold    <= 1'b1;
      r_core_go      <= 1'b0;
      r_core_boot_pc <= '0;
      r_busy         <= 1'b0;
      r_loaded_count <= '0;
    end else begin
      r_prf_we  <= 1'b0;
      r_core_go <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.init_start) begin
            r_core_boot_pc <= bus.init_boot_pc;
            r_counter      <= '0;
            r_loaded_count <= '0;
            r_busy         <= 1'b1;
            r_state        <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_prf_we    <= 1'b1;
          r_prf_waddr <= bus.rat_rd_phys;
          r_prf_wdata <= '0;
          r_counter   <= r_counter + 1'b1;
          if (r_counter == LAST_IDX) begin
            r_load_ready <= 1'b1;
            r_state      <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (w_handshake) begin
            // x0 is hardwired zero, so its beat is swallowed without a write.
            if (bus.load_reg != '0) begin
              r_prf_we    <= 1'b1;
              r_prf_waddr <= bus.rat_rd_phys;
              r_prf_wdata <= bus.load_data;
              if (r_loaded_count != COUNT_MAX)
                r_loaded_count <= r_loaded_count + 1'b1;
            end
            if (bus.load_last) begin
              r_load_ready <= 1'b0;
              r_busy       <= 1'b0;
              r_core_go    <= 1'b1;
              r_core_hold  <= 1'b0;
              r_state      <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_DONE;
        end
      endcase
    end
  end

  assign bus.load_ready   = r_load_ready;
  assign bus.rat_rd_idx   = w_rat_idx;
  assign bus.prf_we       = r_prf_we;
  assign bus.prf_waddr    = r_prf_waddr;
  assign bus.prf_wdata    = r_prf_wdata;
  assign bus.core_hold    = r_core_hold;
  assign bus.core_go      = r_core_go;
  assign bus.core_boot_pc = r_core_boot_pc;
  assign bus.busy         = r_busy;
  assign bus.loaded_count = r_loaded_count;

endmodule

// File: tb/tb_arch_state_loader.sv
// tb/tb_arch_state_loader.sv - directed bench for arch_state_loader
module tb_arch_state_loader;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  int   wr_n;
  int   go_n;
  logic [5:0]  wa [0:255];
  logic [31:0] wd [0:255];
  int          wc [0:255];
  logic [5:0]  rat_map [0:31];

  arch_state_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_WIDTH(5), .PHY_WIDTH(6)) bus ();

  arch_state_loader #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_WIDTH(5), .ARCH_REGS(32), .PHY_WIDTH(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.rat_rd_phys = rat_map[bus.rat_rd_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    wr_n = 0;
    go_n = 0;
  end
  always @(negedge clk) begin
    if (bus.prf_we === 1'b1 && wr_n < 256) begin
      wa[wr_n] = bus.prf_waddr;
      wd[wr_n] = bus.prf_wdata;
      wc[wr_n] = cyc;
      wr_n     = wr_n + 1;
    end
    if (bus.core_go === 1'b1) go_n = go_n + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic identity_map();
    for (int i = 0; i < 32; i++) rat_map[i] = 6'(i);
  endtask

  task automatic do_clear(input logic [31:0] pc);
    int base;
    int bound;
    base = wr_n;
    bus.init_start   = 1'b1;
    bus.init_boot_pc = pc;
    step();
    bus.init_start = 1'b0;
    check("clear_busy", bus.busy, 1);
    bound = 0;
    while (bus.load_ready !== 1'b1 && bound < 100) begin
      step();
      bound++;
    end
    check("clear_ready", bus.load_ready, 1);
    @(negedge clk);
    #1;
    check("clear_nwrites", wr_n - base, 32);
    for (int i = 0; i < 32; i++) begin
      check("clear_addr", wa[base+i], 64'(i));
      check("clear_data", wd[base+i], 0);
      check("clear_cycle", wc[base+i] - wc[base], 64'(i));
    end
  endtask

  task automatic drive_beat(input logic [4:0] r, input logic [31:0] d, input logic last);
    bus.load_valid = 1'b1;
    bus.load_reg   = r;
    bus.load_data  = d;
    bus.load_last  = last;
  endtask

  task automatic idle_beat();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  initial begin
    int base;
    int go_base;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.init_start   = 1'b0;
    bus.init_boot_pc = '0;
    bus.load_valid   = 1'b0;
    bus.load_reg     = '0;
    bus.load_data    = '0;
    bus.load_last    = 1'b0;
    identity_map();
    #1;

    // 1: reset values, then full clear sweep with an identity RAT
    do_reset();
    check("rst_hold", bus.core_hold, 1);
    check("rst_we", bus.prf_we, 0);
    check("rst_go", bus.core_go, 0);
    check("rst_ready", bus.load_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_waddr", bus.prf_waddr, 0);
    check("rst_wdata", bus.prf_wdata, 0);
    check("rst_pc", bus.core_boot_pc, 0);
    check("rst_count", bus.loaded_count, 0);
    check("rst_ratidx", bus.rat_rd_idx, 0);
    do_clear(32'h0000_1000);
    check("t1_pc", bus.core_boot_pc, 32'h1000);
    check("t1_hold", bus.core_hold, 1);

    // 2: two beats through a non-identity mapping, then release
    rat_map[5]  = 6'd40;
    rat_map[31] = 6'd63;
    base    = wr_n;
    go_base = go_n;
    drive_beat(5'd5, 32'hDEAD_BEEF, 1'b0);
    #1;
    check("t2_ratidx5", bus.rat_rd_idx, 5);
    step();
    check("t2_we1", bus.prf_we, 1);
    check("t2_addr1", bus.prf_waddr, 40);
    check("t2_data1", bus.prf_wdata, 32'hDEAD_BEEF);
    check("t2_count1", bus.loaded_count, 1);
    drive_beat(5'd31, 32'h1234_5678, 1'b1);
    #1;
    check("t2_ratidx31", bus.rat_rd_idx, 31);
    step();
    idle_beat();
    check("t2_we2", bus.prf_we, 1);
    check("t2_addr2", bus.prf_waddr, 63);
    check("t2_data2", bus.prf_wdata, 32'h1234_5678);
    check("t2_go", bus.core_go, 1);
    check("t2_hold_rel", bus.core_hold, 0);
    check("t2_ready_drop", bus.load_ready, 0);
    check("t2_count2", bus.loaded_count, 2);
    step();
    check("t2_go_off", bus.core_go, 0);
    check("t2_we_off", bus.prf_we, 0);
    check("t2_hold_done", bus.core_hold, 0);
    check("t2_busy_done", bus.busy, 0);

    // 6: init_start in DONE is ignored
    bus.init_start = 1'b1;
    step();
    bus.init_start = 1'b0;
    repeat (4) step();
    check("t6_nwrites", wr_n - base, 2);
    check("t6_go_pulses", go_n - go_base, 1);
    check("t6_busy", bus.busy, 0);
    check("t6_ready", bus.load_ready, 0);
    check("t6_hold", bus.core_hold, 0);
    check("t6_count", bus.loaded_count, 2);

    // 3: x0 beat is consumed without a write
    identity_map();
    do_reset();
    do_clear(32'h0000_2000);
    base = wr_n;
    drive_beat(5'd0, 32'hFFFF_FFFF, 1'b0);
    step();
    check("t3_x0_nowe", bus.prf_we, 0);
    check("t3_x0_count", bus.loaded_count, 0);
    drive_beat(5'd1, 32'd7, 1'b1);
    step();
    idle_beat();
    check("t3_we", bus.prf_we, 1);
    check("t3_addr", bus.prf_waddr, 1);
    check("t3_data", bus.prf_wdata, 7);
    check("t3_count", bus.loaded_count, 1);
    repeat (2) step();
    check("t3_nwrites", wr_n - base, 1);

    // 4: gap in load_valid, duplicate index, later beat wins
    do_reset();
    do_clear(32'h0000_3000);
    base = wr_n;
    drive_beat(5'd2, 32'd1, 1'b0);
    step();
    idle_beat();
    check("t4_we1", bus.prf_we, 1);
    check("t4_data1", bus.prf_wdata, 1);
    step();
    check("t4_gap_nowe", bus.prf_we, 0);
    drive_beat(5'd2, 32'd2, 1'b1);
    step();
    idle_beat();
    check("t4_we2", bus.prf_we, 1);
    check("t4_addr2", bus.prf_waddr, 2);
    check("t4_data2", bus.prf_wdata, 2);
    check("t4_count", bus.loaded_count, 2);
    repeat (2) step();
    check("t4_nwrites", wr_n - base, 2);
    check("t4_final", wd[wr_n-1], 2);

    // 5: asynchronous reset mid-clear, then a clean restart from index 0
    do_reset();
    bus.init_start   = 1'b1;
    bus.init_boot_pc = 32'h0000_4000;
    step();
    bus.init_start = 1'b0;
    repeat (10) step();
    check("t5_idx10", bus.rat_rd_idx, 10);
    check("t5_we_pre", bus.prf_we, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_we_rst", bus.prf_we, 0);
    check("t5_hold_rst", bus.core_hold, 1);
    check("t5_busy_rst", bus.busy, 0);
    check("t5_pc_rst", bus.core_boot_pc, 0);
    base = wr_n;
    step();
    rst = 1'b0;
    step();
    check("t5_no_writes", wr_n - base, 0);
    do_clear(32'h0000_5000);
    check("t5_pc", bus.core_boot_pc, 32'h5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
